elvm_core: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle ELVM CPU. It executes the ELVM instruction set: mov, add, sub, load, store, putc, getc, exit, the six compares and the seven jumps. Instructions come from an external synchronous ROM. Words are WORD_W bits wide, and the data memory is internal, has a configurable depth and is zero-cleared after reset. putc and getc use valid/ready handshakes, so the core stalls on I/O. It sits between the program ROM and the board-level UART/LED glue.

---
 rtl/elvm_pkg.sv | 59 +++++
 rtl/elvm_if.sv | 34 +++
 rtl/elvm_dmem.sv | 22 ++
 rtl/elvm_core.sv | 209 ++++++++++++++++++++
 tb/tb_elvm_core.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elvm_pkg.sv
// Shared constants for the multi-cycle ELVM core: opcodes, instruction
// field layout, register indices and the FSM state encoding.
package elvm_pkg;

  // Instruction layout, MSB first: op, is_imm, rd, rs, imm[WORD_W-1:0].
  // Offsets below are counted from bit WORD_W (the first bit above imm).
  localparam int OP_W         = 5;
  localparam int REG_IDX_W    = 3;
  localparam int RS_OFS       = 0;
  localparam int RD_OFS       = 3;
  localparam int IMM_FLAG_OFS = 6;
  localparam int OP_OFS       = 7;
  localparam int HDR_W        = 12;

  localparam logic [OP_W-1:0] OP_MOV   = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd2;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'd3;
  localparam logic [OP_W-1:0] OP_STORE = 5'd4;
  localparam logic [OP_W-1:0] OP_PUTC  = 5'd5;
  localparam logic [OP_W-1:0] OP_GETC  = 5'd6;
  localparam logic [OP_W-1:0] OP_EXIT  = 5'd7;
  localparam logic [OP_W-1:0] OP_EQ    = 5'd8;
  localparam logic [OP_W-1:0] OP_NE    = 5'd9;
  localparam logic [OP_W-1:0] OP_LT    = 5'd10;
  localparam logic [OP_W-1:0] OP_GT    = 5'd11;
  localparam logic [OP_W-1:0] OP_LE    = 5'd12;
  localparam logic [OP_W-1:0] OP_GE    = 5'd13;
  localparam logic [OP_W-1:0] OP_JEQ   = 5'd14;
  localparam logic [OP_W-1:0] OP_JNE   = 5'd15;
  localparam logic [OP_W-1:0] OP_JLT   = 5'd16;
  localparam logic [OP_W-1:0] OP_JGT   = 5'd17;
  localparam logic [OP_W-1:0] OP_JLE   = 5'd18;
  localparam logic [OP_W-1:0] OP_JGE   = 5'd19;
  localparam logic [OP_W-1:0] OP_JMP   = 5'd20;

  localparam logic [REG_IDX_W-1:0] REG_A  = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_B  = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_C  = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_D  = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_SP = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_BP = 3'd5;
  localparam int                   NUM_REGS = 6;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_PUTC_W = 3'd3,
    ST_GETC_W = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Indices 6 and 7 do not name a register.
  function automatic logic reg_ok(input logic [REG_IDX_W-1:0] idx);
    return idx <= REG_BP;
  endfunction

endpackage

// File: rtl/elvm_if.sv
// Bus between the core and its environment: program ROM, byte I/O, status.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. putc: the core is the source (putc_valid), it holds
// putc_data stable and keeps putc_valid high until that edge. getc: the core
// is the sink (getc_ready); getc_data/getc_eof are sampled only on the
// transfer edge and getc_ready drops in the following cycle.
interface elvm_if #(
  parameter int WORD_W = 24,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]      imem_addr;
  logic [12+WORD_W-1:0] imem_data;
  logic                 putc_valid;
  logic [7:0]           putc_data;
  logic                 putc_ready;
  logic                 getc_ready;
  logic                 getc_valid;
  logic [7:0]           getc_data;
  logic                 getc_eof;
  logic                 halted;
  logic                 error;
  logic                 busy;

  modport master (
    output imem_addr, putc_valid, putc_data, getc_ready, halted, error, busy,
    input  imem_data, putc_ready, getc_valid, getc_data, getc_eof
  );

  modport slave (
    input  imem_addr, putc_valid, putc_data, getc_ready, halted, error, busy,
    output imem_data, putc_ready, getc_valid, getc_data, getc_eof
  );
endinterface

// File: rtl/elvm_dmem.sv
// Data memory: one synchronous write port, one asynchronous read port.
// No reset on the array so it maps to distributed RAM; the core clears it.
module elvm_dmem #(
  parameter int DMEM_AW = 5,
  parameter int WORD_W  = 24
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [DMEM_AW-1:0] waddr_i,
  input  logic [WORD_W-1:0]  wdata_i,
  input  logic [DMEM_AW-1:0] raddr_i,
  output logic [WORD_W-1:0]  rdata_o
);
  logic [WORD_W-1:0] mem_q [2**DMEM_AW];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/elvm_core.sv
// Multi-cycle ELVM CPU: FETCH/EXEC per instruction, stalls on putc/getc
// handshakes, clears data memory after every reset.
module elvm_core
  import elvm_pkg::*;
#(
  parameter int WORD_W  = 24,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  elvm_if.master bus,
  output state_t dbg_state_o
);
  state_t                 st_q;
  logic [PC_W-1:0]        pc_q;
  logic [WORD_W-1:0]      regs_q [NUM_REGS];
  logic [DMEM_AW-1:0]     cnt_q;
  logic [REG_IDX_W-1:0]   rd_sel_q;
  logic                   putc_valid_q;
  logic [7:0]             putc_data_q;
  logic                   getc_ready_q;
  logic                   halted_q;
  logic                   error_q;
  logic                   busy_q;

  logic [OP_W-1:0]        op;
  logic                   is_imm;
  logic [REG_IDX_W-1:0]   rd;
  logic [REG_IDX_W-1:0]   rs;
  logic [WORD_W-1:0]      imm;
  logic [WORD_W-1:0]      rd_val;
  logic [WORD_W-1:0]      rs_val;
  logic [WORD_W-1:0]      src;
  logic                   uses_src;
  logic                   uses_rd;
  logic                   bad;
  logic                   cmp_true;
  logic                   wr_en;
  logic [WORD_W-1:0]      wr_val;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        next_pc;
  logic                   dm_we;
  logic [DMEM_AW-1:0]     dm_waddr;
  logic [WORD_W-1:0]      dm_wdata;
  logic [WORD_W-1:0]      dm_rdata;

  assign op     = bus.imem_data[WORD_W+OP_OFS +: OP_W];
  assign is_imm = bus.imem_data[WORD_W+IMM_FLAG_OFS];
  assign rd     = bus.imem_data[WORD_W+RD_OFS +: REG_IDX_W];
  assign rs     = bus.imem_data[WORD_W+RS_OFS +: REG_IDX_W];
  assign imm    = bus.imem_data[WORD_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);

  // Register file read ports; unused indices read as zero
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd == REG_IDX_W'(i)) rd_val = regs_q[i];
      if (rs == REG_IDX_W'(i)) rs_val = regs_q[i];
    end
  end

  assign src = is_imm ? imm : rs_val;

  // Decode legality: only fields the opcode actually reads are checked
  always_comb begin
    uses_src = (op <= OP_STORE) || (op >= OP_EQ && op <= OP_JGE);
    uses_rd  = uses_src || (op == OP_PUTC) || (op == OP_GETC);
    bad      = (op > OP_JMP) ||
               (uses_rd && !reg_ok(rd)) ||
               (uses_src && !is_imm && !reg_ok(rs));
  end

  // Unsigned relation shared by set-on-compare and conditional jumps
  always_comb begin
    cmp_true = 1'b0;
    case (op)
      OP_EQ, OP_JEQ: cmp_true = (rd_val == src);
      OP_NE, OP_JNE: cmp_true = (rd_val != src);
      OP_LT, OP_JLT: cmp_true = (rd_val <  src);
      OP_GT, OP_JGT: cmp_true = (rd_val >  src);
      OP_LE, OP_JLE: cmp_true = (rd_val <= src);
      OP_GE, OP_JGE: cmp_true = (rd_val >= src);
      default:       cmp_true = 1'b0;
    endcase
  end

  // Result and next pc for instructions that complete in EXEC
  always_comb begin
    wr_en   = 1'b0;
    wr_val  = src;
    next_pc = pc_inc;
    case (op)
      OP_MOV:  wr_en = 1'b1;
      OP_ADD:  begin wr_en = 1'b1; wr_val = rd_val + src; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rd_val - src; end
      OP_LOAD: begin wr_en = 1'b1; wr_val = dm_rdata; end
      OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE: begin
        wr_en  = 1'b1;
        wr_val = {{(WORD_W-1){1'b0}}, cmp_true};
      end
      OP_JEQ, OP_JNE, OP_JLT, OP_JGT, OP_JLE, OP_JGE: begin
        if (cmp_true) next_pc = imm[PC_W-1:0];
      end
      OP_JMP:  next_pc = imm[PC_W-1:0];
      default: ;
    endcase
  end

  // Data memory port steering: CLEAR sweep or store (address from src)
  always_comb begin
    dm_we    = (st_q == ST_CLEAR) ||
               (st_q == ST_EXEC && op == OP_STORE && !bad);
    dm_waddr = (st_q == ST_CLEAR) ? cnt_q : src[DMEM_AW-1:0];
    dm_wdata = (st_q == ST_CLEAR) ? '0 : rd_val;
  end

  elvm_dmem #(.DMEM_AW(DMEM_AW), .WORD_W(WORD_W)) u_dmem (
    .clk     (clk),
    .we_i    (dm_we),
    .waddr_i (dm_waddr),
    .wdata_i (dm_wdata),
    .raddr_i (src[DMEM_AW-1:0]),
    .rdata_o (dm_rdata)
  );

  // Main FSM with architectural state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_CLEAR;
      pc_q         <= '0;
      cnt_q        <= '0;
      rd_sel_q     <= '0;
      putc_valid_q <= 1'b0;
      putc_data_q  <= '0;
      getc_ready_q <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (st_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + DMEM_AW'(1);
          if (cnt_q == {DMEM_AW{1'b1}}) begin
            st_q   <= ST_FETCH;
            busy_q <= 1'b0;
          end
        end
        ST_FETCH: st_q <= ST_EXEC;
        ST_EXEC: begin
          if (bad) begin
            error_q  <= 1'b1;
            halted_q <= 1'b1;
            st_q     <= ST_HALT;
          end else if (op == OP_EXIT) begin
            halted_q <= 1'b1;
            st_q     <= ST_HALT;
          end else if (op == OP_PUTC) begin
            putc_valid_q <= 1'b1;
            putc_data_q  <= rd_val[7:0];
            st_q         <= ST_PUTC_W;
          end else if (op == OP_GETC) begin
            getc_ready_q <= 1'b1;
            rd_sel_q     <= rd;
            st_q         <= ST_GETC_W;
          end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_en && rd == REG_IDX_W'(i)) regs_q[i] <= wr_val;
            end
            pc_q <= next_pc;
            st_q <= ST_FETCH;
          end
        end
        ST_PUTC_W: begin
          if (bus.putc_ready) begin
            putc_valid_q <= 1'b0;
            pc_q         <= pc_inc;
            st_q         <= ST_FETCH;
          end
        end
        ST_GETC_W: begin
          if (bus.getc_valid) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (rd_sel_q == REG_IDX_W'(i))
                regs_q[i] <= bus.getc_eof ? '0 : WORD_W'(bus.getc_data);
            end
            getc_ready_q <= 1'b0;
            pc_q         <= pc_inc;
            st_q         <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: st_q <= ST_HALT;
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.putc_valid = putc_valid_q;
  assign bus.putc_data  = putc_data_q;
  assign bus.getc_ready = getc_ready_q;
  assign bus.halted     = halted_q;
  assign bus.error      = error_q;
  assign bus.busy       = busy_q;
  assign dbg_state_o    = st_q;
endmodule

// File: tb/tb_elvm_core.sv
// Bench for elvm_core: ROM model, putc/getc drivers, ISA-level reference
// model feeding a byte scoreboard, directed programs and random programs.
module tb_elvm_core;
  import elvm_pkg::*;

  localparam int WORD_W  = 24;
  localparam int PC_W    = 8;
  localparam int DMEM_AW = 5;
  localparam int IW      = 12 + WORD_W;

  typedef struct {
    bit         eof;
    logic [7:0] data;
    int         delay;
  } gin_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  elvm_if #(.WORD_W(WORD_W), .PC_W(PC_W)) bus ();

  elvm_core #(.WORD_W(WORD_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- synchronous program ROM ----------------
  logic [IW-1:0] rom [256];
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  // ---------------- scoreboard state ----------------
  logic [7:0]      exp_q [$];
  gin_t            in_q [$];
  int              checks = 0;
  int              failures = 0;
  bit              exp_err;
  logic [PC_W-1:0] exp_pc;
  bit              p_rand = 1'b0;
  int              p_hold = 0;
  int              p_cnt = 0;
  int              gwait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input logic [4:0] op, input logic ii,
                                        input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [WORD_W-1:0] imm);
    return {op, ii, rd, rs, imm};
  endfunction

  function automatic bit rel(input logic [4:0] k, input logic [WORD_W-1:0] a,
                             input logic [WORD_W-1:0] b);
    case (k)
      5'd0:    return a == b;
      5'd1:    return a != b;
      5'd2:    return a < b;
      5'd3:    return a > b;
      5'd4:    return a <= b;
      default: return a >= b;
    endcase
  endfunction

  // ---------------- drivers: putc_ready and getc source ----------------
  initial begin
    bit g_fire;
    bus.putc_ready = 1'b0;
    bus.getc_valid = 1'b0;
    bus.getc_data  = 8'h00;
    bus.getc_eof   = 1'b0;
    forever begin
      @(negedge clk);
      g_fire = rst_n && bus.getc_ready && bus.getc_valid;
      @(posedge clk);
      #2;
      if (g_fire) begin
        bus.getc_valid = 1'b0;
        void'(in_q.pop_front());
        gwait = (in_q.size() > 0) ? in_q[0].delay : 0;
      end else if (!bus.getc_valid && in_q.size() > 0) begin
        if (gwait == 0) begin
          bus.getc_valid = 1'b1;
          bus.getc_data  = in_q[0].data;
          bus.getc_eof   = in_q[0].eof;
        end else if (bus.getc_ready) begin
          gwait--;
        end
      end
      if (bus.putc_valid) p_cnt++;
      else p_cnt = 0;
      bus.putc_ready = p_rand ? 1'($urandom_range(0, 1)) : (p_cnt > p_hold);
    end
  end

  // ---------------- monitor: every accepted putc byte ----------------
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && bus.putc_valid && bus.putc_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL putc_unexpected actual=%02h expected=none", bus.putc_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("putc_byte", bus.putc_data, exp_b);
        end
      end
    end
  end

  // ---------------- ISA-level reference model ----------------
  task automatic run_model();
    logic [WORD_W-1:0] r [8];
    logic [WORD_W-1:0] m [32];
    logic [PC_W-1:0]   pc;
    logic [4:0]        op;
    logic              ii;
    logic [2:0]        rd, rs;
    logic [WORD_W-1:0] imm, src, a;
    int                gi;
    bit                done, jumped, uses_rd, uses_src;
    for (int i = 0; i < 8; i++) r[i] = '0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    pc = '0; gi = 0; done = 1'b0; exp_err = 1'b0;
    for (int step = 0; step < 4000 && !done; step++) begin
      {op, ii, rd, rs, imm} = rom[pc];
      src = ii ? imm : r[rs];
      a = r[rd];
      uses_src = (op <= 5'd4) || (op >= 5'd8 && op <= 5'd19);
      uses_rd  = uses_src || op == 5'd5 || op == 5'd6;
      jumped = 1'b0;
      if (op > 5'd20 || (uses_rd && rd > 3'd5) || (uses_src && !ii && rs > 3'd5)) begin
        exp_err = 1'b1;
        done = 1'b1;
      end else if (op == 5'd7) begin
        done = 1'b1;
      end else begin
        case (op)
          5'd0: r[rd] = src;
          5'd1: r[rd] = a + src;
          5'd2: r[rd] = a - src;
          5'd3: r[rd] = m[src[4:0]];
          5'd4: m[src[4:0]] = a;
          5'd5: exp_q.push_back(a[7:0]);
          5'd6: begin
            if (gi < in_q.size()) r[rd] = in_q[gi].eof ? '0 : {16'h0, in_q[gi].data};
            gi++;
          end
          default: begin
            if (op <= 5'd13) r[rd] = {23'h0, rel(op - 5'd8, a, src)};
            else if (op <= 5'd19) begin
              if (rel(op - 5'd14, a, src)) begin pc = imm[PC_W-1:0]; jumped = 1'b1; end
            end else begin
              pc = imm[PC_W-1:0];
              jumped = 1'b1;
            end
          end
        endcase
        if (!jumped) pc = pc + 8'd1;
      end
    end
    exp_pc = pc;
  endtask

  // ---------------- one program run: reset, clear, execute, halt ----------------
  task automatic run_prog();
    int n;
    rst_n = 1'b0;
    exp_q.delete();
    run_model();
    gwait = (in_q.size() > 0) ? in_q[0].delay : 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("busy_cycles", n, 32);
    check("first_fetch_addr", bus.imem_addr, 0);
    n = 0;
    while (!bus.halted && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", bus.halted, 1);
    check("error_flag", bus.error, exp_err);
    check("halt_pc", bus.imem_addr, exp_pc);
    repeat (6) @(negedge clk);
    check("pc_frozen", bus.imem_addr, exp_pc);
    check("bytes_left", exp_q.size(), 0);
    check("putc_idle", bus.putc_valid, 0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_EXIT, 1'b0, 3'd0, 3'd0, '0);
    in_q.delete();
  endtask

  task automatic gen_random();
    int len, body, k;
    logic [2:0] rd, rs;
    logic [WORD_W-1:0] imm;
    logic ii;
    logic [4:0] op;
    gin_t g;
    clear_rom();
    len = $urandom_range(10, 24);
    body = len - 7;
    for (int i = 0; i < body; i++) begin
      k  = $urandom_range(0, 99);
      rd = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rs = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      ii = 1'($urandom_range(0, 1));
      imm = ($urandom_range(0, 1) == 1) ? WORD_W'($urandom_range(0, 40)) : WORD_W'($urandom());
      if (k < 18) op = OP_MOV;
      else if (k < 30) op = OP_ADD;
      else if (k < 42) op = OP_SUB;
      else if (k < 50) op = OP_LOAD;
      else if (k < 58) op = OP_STORE;
      else if (k < 64) op = OP_PUTC;
      else if (k < 70) begin
        op = OP_GETC;
        g.eof = ($urandom_range(0, 4) == 0);
        g.data = 8'($urandom());
        g.delay = $urandom_range(0, 3);
        in_q.push_back(g);
      end else if (k < 80) op = OP_EQ + 5'($urandom_range(0, 5));
      else if (k < 90) begin
        op = OP_JEQ + 5'($urandom_range(0, 5));
        imm = WORD_W'($urandom_range(i + 1, len - 1));
      end else if (k < 95) begin
        op = OP_JMP;
        imm = WORD_W'($urandom_range(i + 1, len - 1));
      end else if (k < 98) op = 5'($urandom_range(21, 31));
      else op = OP_EXIT;
      rom[i] = enc(op, ii, rd, rs, imm);
    end
    for (int j = 0; j < 6; j++) rom[body + j] = enc(OP_PUTC, 1'b0, 3'(j), 3'd0, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    // Hello: two bytes, sink stalls 5 cycles per byte
    clear_rom();
    rom[0] = enc(OP_MOV,  1'b1, REG_A, 3'd0, 24'd72);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    rom[2] = enc(OP_MOV,  1'b1, REG_A, 3'd0, 24'd105);
    rom[3] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    p_rand = 1'b0; p_hold = 5;
    run_prog();

    // Store/load/wrapping add/jne taken
    clear_rom();
    rom[0] = enc(OP_MOV,   1'b1, REG_B, 3'd0,  24'd3);
    rom[1] = enc(OP_STORE, 1'b1, REG_B, 3'd0,  24'd10);
    rom[2] = enc(OP_LOAD,  1'b1, REG_C, 3'd0,  24'd10);
    rom[3] = enc(OP_ADD,   1'b1, REG_C, 3'd0,  24'hFFFFFF);
    rom[4] = enc(OP_JNE,   1'b0, REG_C, REG_B, 24'd7);
    rom[5] = enc(OP_MOV,   1'b1, REG_D, 3'd0,  24'h35);
    rom[6] = enc(OP_PUTC,  1'b0, REG_D, 3'd0,  24'd0);
    rom[7] = enc(OP_PUTC,  1'b0, REG_C, 3'd0,  24'd0);
    p_hold = 0;
    run_prog();
    // Same program with add C,0: branch falls through to pc 5
    rom[3] = enc(OP_ADD,   1'b1, REG_C, 3'd0,  24'd0);
    run_prog();

    // Memory is cleared on every reset
    clear_rom();
    rom[0] = enc(OP_LOAD, 1'b1, REG_A, 3'd0, 24'd10);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    rom[2] = enc(OP_LOAD, 1'b1, REG_B, 3'd0, 24'd63);
    rom[3] = enc(OP_PUTC, 1'b0, REG_B, 3'd0, 24'd0);
    run_prog();

    // getc with delayed data, then an EOF byte that must yield 0
    clear_rom();
    rom[0] = enc(OP_GETC, 1'b0, REG_A, 3'd0, 24'd0);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    rom[2] = enc(OP_GETC, 1'b0, REG_A, 3'd0, 24'd0);
    rom[3] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    in_q.push_back('{eof: 1'b0, data: 8'h41, delay: 4});
    in_q.push_back('{eof: 1'b1, data: 8'h5A, delay: 2});
    run_prog();

    // Illegal opcode at pc 3
    clear_rom();
    rom[0] = enc(OP_MOV,  1'b1, REG_A, 3'd0, 24'd1);
    rom[1] = enc(OP_MOV,  1'b1, REG_B, 3'd0, 24'd2);
    rom[2] = enc(OP_MOV,  1'b1, REG_C, 3'd0, 24'd3);
    rom[3] = enc(5'd25,   1'b0, REG_A, 3'd0, 24'd0);
    rom[4] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    run_prog();

    // Reset pulsed while a putc is pending
    clear_rom();
    rom[0] = enc(OP_MOV,  1'b1, REG_A, 3'd0, 24'd72);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    p_hold = 1000;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (!bus.putc_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("putc_pending", bus.putc_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_putc_valid", bus.putc_valid, 0);
    check("rst_putc_data", bus.putc_data, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_imem_addr", bus.imem_addr, 0);
    p_hold = 3;
    run_prog();

    // Random programs, random sink backpressure
    p_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      gen_random();
      run_prog();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
